// File: rtl/convolution_controller.sv
// Streaming KxK convolution front-end: buffers a pixel window, launches the external
// MAC array per window and forwards its sum on an AXI4-Stream master.
module convolution_controller #(
   parameter int unsigned DATA_WIDTH     = 8,
   parameter int unsigned KERNEL_SIZE    = 3,
   parameter int unsigned AXI_ADDR_WIDTH = 10
) (
   input  logic                                           axi_clk,
   input  logic                                           axi_reset_n,
   input  logic [DATA_WIDTH-1:0]                          cSum,
   input  logic                                           cReady,
   output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0]  MULTIPLIER_INPUT,
   output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0]  MULTIPLICAND_INPUT,
   output logic [KERNEL_SIZE*KERNEL_SIZE-1:0]             MULTIPLY_START,
   input  logic                                           s_axis_valid,
   input  logic [DATA_WIDTH-1:0]                          s_axis_data,
   output logic                                           s_axis_ready,
   input  logic                                           s_axis_last,
   input  logic [DATA_WIDTH/8-1:0]                        s_axis_keep,
   output logic                                           m_axis_valid,
   output logic [DATA_WIDTH-1:0]                          m_axis_data,
   input  logic                                           m_axis_ready,
   output logic                                           m_axis_last,
   output logic [DATA_WIDTH/8-1:0]                        m_axis_keep,
   input  logic [AXI_ADDR_WIDTH-1:0]                      s_axi_awaddr,
   output logic                                           s_axi_awready,
   input  logic                                           s_axi_awvalid,
   input  logic [DATA_WIDTH-1:0]                          s_axi_wdata,
   output logic                                           s_axi_wready,
   input  logic                                           s_axi_wvalid,
   input  logic [AXI_ADDR_WIDTH-1:0]                      s_axi_araddr,
   output logic                                           s_axi_arready,
   input  logic                                           s_axi_arvalid,
   output logic [DATA_WIDTH-1:0]                          s_axi_rdata,
   input  logic                                           s_axi_rready,
   output logic                                           s_axi_rvalid,
   output logic                                           s_axi_bvalid,
   input  logic                                           s_axi_bready
);
   localparam int unsigned DW = DATA_WIDTH;
   localparam int unsigned K  = KERNEL_SIZE;
   localparam int unsigned N  = K * K;
   localparam int unsigned AW = AXI_ADDR_WIDTH;
   localparam int unsigned IW = AW - 2;
   localparam int unsigned CW = DW + 1;
   localparam int unsigned BW = $clog2(N + 1);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_WAIT, S_OUT, S_DONE} state_t;

   state_t          r_state, w_next;
   logic            r_axi_rdy, r_bvalid, r_rvalid;
   logic [DW-1:0]   r_rdata, w_rmux;
   logic            r_en, r_done;
   logic [DW-1:0]   r_width, r_height;
   logic [DW-1:0]   r_coef [N];
   logic [DW-1:0]   r_win  [N];
   logic [DW-1:0]   r_col, r_band, r_mdata;
   logic [BW-1:0]   r_beat, w_need;
   logic            r_full;
   logic [IW-1:0]   w_widx, w_ridx;
   logic            w_wr, w_waligned, w_sreset, w_accept, w_load_done;
   logic            w_col_last, w_band_last, w_busy;
   logic            w_s_ready, w_start, w_mvalid, w_mlast;
   logic            w_unused;

   assign w_unused    = ^{s_axis_last, s_axis_keep};
   assign w_widx      = s_axi_awaddr[AW-1:2];
   assign w_ridx      = s_axi_araddr[AW-1:2];
   assign w_waligned  = (s_axi_awaddr[1:0] == 2'b00);
   assign w_wr        = s_axi_awvalid && s_axi_wvalid && r_axi_rdy;
   assign w_sreset    = w_wr && w_waligned && (w_widx == IW'(1)) && s_axi_wdata[0];
   assign w_busy      = (r_state != S_IDLE);
   assign w_accept    = (r_state == S_LOAD) && r_en && s_axis_valid;
   assign w_need      = r_full ? BW'(N) : BW'(K);
   assign w_load_done = w_accept && (BW'(r_beat + BW'(1)) == w_need);
   assign w_col_last  = (CW'(r_col) + CW'(K)) >= CW'(r_width);
   assign w_band_last = (CW'(r_band) + CW'(K)) >= CW'(r_height);

   // AXI handshake: ready held high out of reset, responses held until accepted
   always_ff @(posedge axi_clk or negedge axi_reset_n) begin
      if (!axi_reset_n) begin
         r_axi_rdy <= 1'b0;
         r_bvalid  <= 1'b0;
         r_rvalid  <= 1'b0;
         r_rdata   <= '0;
      end else begin
         r_axi_rdy <= 1'b1;
         if (w_wr)              r_bvalid <= 1'b1;
         else if (s_axi_bready) r_bvalid <= 1'b0;
         if (s_axi_arvalid && r_axi_rdy) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rmux;
         end else if (s_axi_rready) begin
            r_rvalid <= 1'b0;
         end
      end
   end

   always_comb begin
      w_rmux = '0;
      if (s_axi_araddr[1:0] == 2'b00) begin
         if (w_ridx == IW'(0)) w_rmux = DW'(r_en);
         if (w_ridx == IW'(2)) w_rmux = DW'({r_done, w_busy});
         if (w_ridx == IW'(4)) w_rmux = r_width;
         if (w_ridx == IW'(5)) w_rmux = r_height;
         for (int unsigned k = 0; k < N; k++)
            if (w_ridx == IW'(6 + k)) w_rmux = r_coef[k];
      end
   end

   always_ff @(posedge axi_clk or negedge axi_reset_n) begin
      if (!axi_reset_n) begin
         r_en     <= 1'b0;
         r_width  <= '0;
         r_height <= '0;
         for (int unsigned k = 0; k < N; k++) r_coef[k] <= '0;
      end else if (w_sreset) begin
         r_en     <= 1'b0;
         r_width  <= '0;
         r_height <= '0;
         for (int unsigned k = 0; k < N; k++) r_coef[k] <= '0;
      end else if (w_wr && w_waligned) begin
         if (w_widx == IW'(0)) r_en     <= s_axi_wdata[0];
         if (w_widx == IW'(4)) r_width  <= s_axi_wdata;
         if (w_widx == IW'(5)) r_height <= s_axi_wdata;
         for (int unsigned k = 0; k < N; k++)
            if (w_widx == IW'(6 + k)) r_coef[k] <= s_axi_wdata;
      end
   end

   always_ff @(posedge axi_clk or negedge axi_reset_n) begin
      if (!axi_reset_n)  r_state <= S_IDLE;
      else if (w_sreset) r_state <= S_IDLE;
      else               r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (r_en && (r_width >= DW'(K)) && (r_height >= DW'(K))) w_next = S_LOAD;
         S_LOAD:  if (w_load_done) w_next = S_START;
         S_START: w_next = S_WAIT;
         S_WAIT:  if (cReady) w_next = S_OUT;
         S_OUT:   if (m_axis_ready) w_next = (w_col_last && w_band_last) ? S_DONE : S_LOAD;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_s_ready = 1'b0;
      w_start   = 1'b0;
      w_mvalid  = 1'b0;
      w_mlast   = 1'b0;
      case (r_state)
         S_LOAD:  w_s_ready = r_en;
         S_START: w_start   = 1'b1;
         S_OUT: begin
            w_mvalid = 1'b1;
            w_mlast  = w_col_last && w_band_last;
         end
         default: ;
      endcase
   end

   // Window fill/slide, position counters and result capture
   always_ff @(posedge axi_clk or negedge axi_reset_n) begin
      if (!axi_reset_n || w_sreset) begin
         r_col   <= '0;
         r_band  <= '0;
         r_beat  <= '0;
         r_full  <= 1'b1;
         r_done  <= 1'b0;
         r_mdata <= '0;
         for (int unsigned k = 0; k < N; k++) r_win[k] <= '0;
      end else begin
         case (r_state)
            S_IDLE: if (w_next == S_LOAD) begin
               r_col  <= '0;
               r_band <= '0;
               r_beat <= '0;
               r_full <= 1'b1;
               r_done <= 1'b0;
            end
            S_LOAD: if (w_accept) begin
               r_beat <= w_load_done ? '0 : BW'(r_beat + BW'(1));
               if (r_full) begin
                  for (int unsigned k = 0; k < N; k++)
                     if (BW'(k) == r_beat) r_win[k] <= s_axis_data;
               end else begin
                  for (int unsigned j = 0; j < K; j++)
                     if (BW'(j) == r_beat) begin
                        for (int unsigned g = 0; g + 1 < K; g++)
                           r_win[g*K + j] <= r_win[(g+1)*K + j];
                        r_win[(K-1)*K + j] <= s_axis_data;
                     end
               end
            end
            S_WAIT: if (cReady) r_mdata <= cSum;
            S_OUT: if (m_axis_ready) begin
               r_full <= w_col_last;
               if (w_col_last) begin
                  r_col  <= '0;
                  r_band <= r_band + DW'(1);
               end else begin
                  r_col  <= r_col + DW'(1);
               end
            end
            S_DONE: r_done <= 1'b1;
            default: ;
         endcase
      end
   end

   for (genvar k = 0; k < N; k++) begin : g_slot
      assign MULTIPLIER_INPUT[k*DW +: DW]   = r_win[k];
      assign MULTIPLICAND_INPUT[k*DW +: DW] = r_coef[k];
   end

   assign MULTIPLY_START = {N{w_start}};
   assign s_axis_ready   = w_s_ready;
   assign m_axis_valid   = w_mvalid;
   assign m_axis_last    = w_mlast;
   assign m_axis_keep    = {(DW/8){w_mvalid}};
   assign m_axis_data    = r_mdata;
   assign s_axi_awready  = r_axi_rdy;
   assign s_axi_wready   = r_axi_rdy;
   assign s_axi_arready  = r_axi_rdy;
   assign s_axi_bvalid   = r_bvalid;
   assign s_axi_rvalid   = r_rvalid;
   assign s_axi_rdata    = r_rdata;
endmodule

// File: tb/tb_convolution_controller.sv
// Self-checking bench for convolution_controller: MAC accelerator model plus a
// result scoreboard filled from a reference window model as pixels are queued.
module tb_convolution_controller;
   localparam int DW = 8;
   localparam int K  = 3;
   localparam int N  = 9;
   localparam int AW = 10;

   logic            axi_clk = 1'b0;
   logic            axi_reset_n = 1'b0;
   logic [DW-1:0]   cSum = '0;
   logic            cReady = 1'b0;
   logic [N*DW-1:0] MULTIPLIER_INPUT, MULTIPLICAND_INPUT;
   logic [N-1:0]    MULTIPLY_START;
   logic            s_axis_valid, s_axis_ready, s_axis_last;
   logic [DW-1:0]   s_axis_data;
   logic [DW/8-1:0] s_axis_keep;
   logic            m_axis_valid, m_axis_ready, m_axis_last;
   logic [DW-1:0]   m_axis_data;
   logic [DW/8-1:0] m_axis_keep;
   logic [AW-1:0]   s_axi_awaddr, s_axi_araddr;
   logic            s_axi_awready, s_axi_awvalid, s_axi_wready, s_axi_wvalid;
   logic            s_axi_arready, s_axi_arvalid, s_axi_rready, s_axi_rvalid;
   logic            s_axi_bvalid, s_axi_bready;
   logic [DW-1:0]   s_axi_wdata, s_axi_rdata;

   convolution_controller #(.DATA_WIDTH(DW), .KERNEL_SIZE(K), .AXI_ADDR_WIDTH(AW)) dut (
      .axi_clk(axi_clk), .axi_reset_n(axi_reset_n), .cSum(cSum), .cReady(cReady),
      .MULTIPLIER_INPUT(MULTIPLIER_INPUT), .MULTIPLICAND_INPUT(MULTIPLICAND_INPUT),
      .MULTIPLY_START(MULTIPLY_START),
      .s_axis_valid(s_axis_valid), .s_axis_data(s_axis_data), .s_axis_ready(s_axis_ready),
      .s_axis_last(s_axis_last), .s_axis_keep(s_axis_keep),
      .m_axis_valid(m_axis_valid), .m_axis_data(m_axis_data), .m_axis_ready(m_axis_ready),
      .m_axis_last(m_axis_last), .m_axis_keep(m_axis_keep),
      .s_axi_awaddr(s_axi_awaddr), .s_axi_awready(s_axi_awready), .s_axi_awvalid(s_axi_awvalid),
      .s_axi_wdata(s_axi_wdata), .s_axi_wready(s_axi_wready), .s_axi_wvalid(s_axi_wvalid),
      .s_axi_araddr(s_axi_araddr), .s_axi_arready(s_axi_arready), .s_axi_arvalid(s_axi_arvalid),
      .s_axi_rdata(s_axi_rdata), .s_axi_rready(s_axi_rready), .s_axi_rvalid(s_axi_rvalid),
      .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready)
   );

   always #5 axi_clk = ~axi_clk;

   int            n_cmp = 0;
   int            n_err = 0;
   logic [DW:0]   exp_q [$];
   logic [DW-1:0] pix_q [$];
   logic [DW-1:0] coef_m [N];

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   // Accelerator model: sum of products, returned a few cycles after the start strobe
   int            acc_cnt = 0;
   logic [DW-1:0] acc_sum = '0;
   always @(negedge axi_clk) begin
      int s;
      cReady = 1'b0;
      if (acc_cnt == 1) begin
         cReady = 1'b1;
         cSum   = acc_sum;
      end
      if (acc_cnt != 0) acc_cnt--;
      if (&MULTIPLY_START) begin
         s = 0;
         for (int k = 0; k < N; k++)
            s += int'(MULTIPLIER_INPUT[k*DW +: DW]) * int'(MULTIPLICAND_INPUT[k*DW +: DW]);
         acc_sum = DW'(s);
         acc_cnt = 3;
      end
   end

   task automatic axi_write(input int addr, input int data);
      @(negedge axi_clk);
      s_axi_awaddr  = AW'(addr);
      s_axi_wdata   = DW'(data);
      s_axi_awvalid = 1'b1;
      s_axi_wvalid  = 1'b1;
      @(negedge axi_clk);
      s_axi_awvalid = 1'b0;
      s_axi_wvalid  = 1'b0;
      @(negedge axi_clk);
      check_eq("bvalid_held", s_axi_bvalid, 1);
      s_axi_bready = 1'b1;
      @(negedge axi_clk);
      s_axi_bready = 1'b0;
   endtask

   task automatic axi_read(input int addr, output logic [DW-1:0] data);
      @(negedge axi_clk);
      s_axi_araddr  = AW'(addr);
      s_axi_arvalid = 1'b1;
      @(negedge axi_clk);
      s_axi_arvalid = 1'b0;
      check_eq("rvalid", s_axi_rvalid, 1);
      data = s_axi_rdata;
      s_axi_rready = 1'b1;
      @(negedge axi_clk);
      s_axi_rready = 1'b0;
   endtask

   // mode 1: pixels count 0..N-1 cyclically; mode 0: every pixel equals val
   task automatic run_frame(input int w, input int h, input int mode, input int val, input bit stall);
      logic [DW-1:0] wm [N];
      logic [DW-1:0] v;
      int p, s, n_out;
      pix_q.delete();
      exp_q.delete();
      p = 0;
      for (int b = 0; b <= h - K; b++)
         for (int c = 0; c <= w - K; c++) begin
            if (c == 0) begin
               for (int k = 0; k < N; k++) begin
                  v = (mode == 1) ? DW'(p % N) : DW'(val);
                  p++;
                  pix_q.push_back(v);
                  wm[k] = v;
               end
            end else begin
               for (int j = 0; j < K; j++) begin
                  v = (mode == 1) ? DW'(p % N) : DW'(val);
                  p++;
                  pix_q.push_back(v);
                  for (int g = 0; g < K - 1; g++) wm[g*K + j] = wm[(g+1)*K + j];
                  wm[(K-1)*K + j] = v;
               end
            end
            s = 0;
            for (int k = 0; k < N; k++) s += int'(wm[k]) * int'(coef_m[k]);
            exp_q.push_back({(b == h - K) && (c == w - K), DW'(s)});
         end
      n_out = exp_q.size();
      for (int k = 0; k < N; k++) axi_write(24 + 4*k, int'(coef_m[k]));
      axi_write(16, w);
      axi_write(20, h);
      axi_write(0, 1);
      fork
         begin : drive
            int idx, cyc;
            idx = 0;
            cyc = 0;
            while (idx < pix_q.size() && cyc < 40000) begin
               @(negedge axi_clk);
               cyc++;
               s_axis_valid = ($urandom_range(0, 3) != 0);
               s_axis_data  = pix_q[idx];
               if (s_axis_valid && s_axis_ready) idx++;
            end
            @(negedge axi_clk);
            s_axis_valid = 1'b0;
            if (idx < pix_q.size()) check_eq("input_timeout", idx, pix_q.size());
         end
         begin : monitor
            int cnt, cyc;
            bit prev_hs, stalled;
            logic [DW:0]   e;
            logic [DW-1:0] held;
            cnt = 0;
            cyc = 0;
            prev_hs = 0;
            stalled = 0;
            while (cnt < n_out && cyc < 40000) begin
               @(negedge axi_clk);
               cyc++;
               if (prev_hs) check_eq("valid_gap", m_axis_valid, 0);
               prev_hs = 0;
               if (m_axis_valid) begin
                  if (stall && !stalled) begin
                     stalled = 1;
                     m_axis_ready = 1'b0;
                     held = m_axis_data;
                     repeat (5) begin
                        @(negedge axi_clk);
                        cyc++;
                        check_eq("stall_valid", m_axis_valid, 1);
                        check_eq("stall_data", m_axis_data, held);
                        check_eq("stall_s_ready", s_axis_ready, 0);
                     end
                  end
                  m_axis_ready = 1'b1;
                  check_eq("m_keep", m_axis_keep, 1);
                  if (exp_q.size() == 0) begin
                     check_eq("unexpected_result", 1, 0);
                  end else begin
                     e = exp_q.pop_front();
                     check_eq("m_data", m_axis_data, e[DW-1:0]);
                     check_eq("m_last", m_axis_last, e[DW]);
                  end
                  cnt++;
                  prev_hs = 1;
               end else begin
                  m_axis_ready = 1'($urandom_range(0, 1));
               end
            end
            @(negedge axi_clk);
            if (prev_hs) check_eq("valid_gap", m_axis_valid, 0);
            m_axis_ready = 1'b0;
            check_eq("result_count", cnt, n_out);
         end
      join
      check_eq("results_left", exp_q.size(), 0);
      axi_write(4, 1);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DW-1:0] rd;
      s_axis_valid = 1'b0; s_axis_data = '0; s_axis_last = 1'b0; s_axis_keep = '1;
      m_axis_ready = 1'b0;
      s_axi_awaddr = '0; s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wvalid = 1'b0;
      s_axi_araddr = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0; s_axi_bready = 1'b0;
      repeat (3) @(negedge axi_clk);
      check_eq("awready_in_reset", s_axi_awready, 0);
      axi_reset_n = 1'b1;
      repeat (2) @(negedge axi_clk);
      check_eq("rst_awready", s_axi_awready, 1);
      check_eq("rst_wready", s_axi_wready, 1);
      check_eq("rst_arready", s_axi_arready, 1);
      check_eq("rst_s_ready", s_axis_ready, 0);
      check_eq("rst_m_valid", m_axis_valid, 0);
      check_eq("rst_m_last", m_axis_last, 0);
      check_eq("rst_m_data", m_axis_data, 0);
      check_eq("rst_start", MULTIPLY_START, 0);
      check_eq("rst_bvalid", s_axi_bvalid, 0);
      check_eq("rst_rvalid", s_axi_rvalid, 0);
      check_eq("rst_window", 32'(|MULTIPLIER_INPUT), 0);
      check_eq("rst_coef", 32'(|MULTIPLICAND_INPUT), 0);

      // Register port
      axi_write(40, 8'h5A);
      axi_read(40, rd);
      check_eq("coef4_read", rd, 8'h5A);
      check_eq("coef4_bus", MULTIPLICAND_INPUT[4*DW +: DW], 8'h5A);
      axi_read(44, rd);
      check_eq("coef5_read", rd, 0);
      axi_write(100, 8'h33);
      axi_read(100, rd);
      check_eq("unmapped_read", rd, 0);
      axi_write(16, 25);
      axi_read(16, rd);
      check_eq("width_read", rd, 25);
      axi_write(4, 1);
      axi_read(16, rd);
      check_eq("width_after_sreset", rd, 0);
      axi_read(40, rd);
      check_eq("coef4_after_sreset", rd, 0);
      axi_read(4, rd);
      check_eq("sreset_reads_zero", rd, 0);
      axi_read(8, rd);
      check_eq("status_idle", rd, 0);
      repeat (4) @(negedge axi_clk);
      check_eq("s_ready_after_sreset", s_axis_ready, 0);

      // Two windows with counting pixels, with output backpressure on the first
      for (int k = 0; k < N; k++) coef_m[k] = DW'(k);
      run_frame(4, 3, 1, 0, 1'b1);

      // Single window that wraps the 8-bit sum
      for (int k = 0; k < N; k++) coef_m[k] = DW'(1);
      run_frame(3, 3, 0, 200, 1'b0);

      // Full 25x25 frame of ones
      for (int k = 0; k < N; k++) coef_m[k] = DW'(k);
      run_frame(25, 25, 0, 1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
